seq_gen: RTL and testbench

Serial frame transmitter; the transmit-side counterpart of the team's `seq_det` sync-word detector. It accepts parallel payload words over a valid/ready handshake and emits on a single serial line, one bit per clock: an 8-bit sync word, then the payload, both MSB first. Its `ser_data` drives the detector's serial input directly, so frames from this block are found by `seq_det` configured with the same pattern.

---
 rtl/seq_gen.sv | 148 ++++++++++++++
 tb/tb_seq_gen.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_gen.sv
// -----------------------------------------------------------------------------
// seq_gen -- serial frame transmitter.
//
// Accepts DATA_W-bit payload words over a valid/ready handshake. For each word
// it sends one frame on ser_data, one bit per clock: the 8-bit SYNC word, MSB
// first, followed by the payload, MSB first. When no frame is in flight the
// line sits at IDLE_BIT. A frame accepted while the previous frame's last bit
// is on the line follows it with no idle gap.
//
// Parameters:
//   SYNC      sync word sent at the start of every frame
//   DATA_W    payload width in bits (1..32)
//   IDLE_BIT  line level when no frame is in flight
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   data_in      in   payload word, sampled only at a handshake
//   data_valid   in   data_in is valid
//   data_ready   out  word can be accepted this cycle (registered)
//   ser_data     out  serial line (registered)
//   sync_active  out  ser_data currently carries a sync bit (registered)
//   frame_done   out  ser_data currently carries the last payload bit
// -----------------------------------------------------------------------------
module seq_gen #(
    parameter logic [7:0] SYNC     = 8'b10011001,
    parameter int         DATA_W   = 8,
    parameter logic       IDLE_BIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              ser_data,
    output logic              sync_active,
    output logic              frame_done
);

    // Counter must index both the 8 sync bits and the DATA_W payload bits.
    localparam int CNT_W = (DATA_W > 8) ? $clog2(DATA_W) : 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PAYLOAD
    } state_t;

    // state/cnt describe the bit that will be put on the line at the next edge;
    // the outputs are registered copies of what that edge produced.
    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [DATA_W-1:0]   shreg, shreg_n;
    logic                ser_n, sync_n, done_n, ready_n;
    logic                accept;

    assign accept = data_valid && data_ready;

    // NOTE: every variable assigned below gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        ser_n   = IDLE_BIT;
        sync_n  = 1'b0;
        done_n  = 1'b0;
        ready_n = 1'b0;

        unique case (state)
            ST_IDLE: begin
                ready_n = 1'b1;
                if (accept) begin
                    shreg_n = data_in;
                    state_n = ST_SYNC;
                    ready_n = 1'b0;
                    // frame_done high means the previous frame's last bit is on
                    // the line right now: start the sync word on this very edge
                    // so back-to-back frames have no idle gap. From a true idle
                    // line the first sync bit follows one cycle later.
                    if (frame_done) begin
                        ser_n  = SYNC[7];
                        sync_n = 1'b1;
                        cnt_n  = CNT_W'(6);
                    end else begin
                        cnt_n  = CNT_W'(7);
                    end
                end
            end

            ST_SYNC: begin
                ser_n  = SYNC[cnt[2:0]];
                sync_n = 1'b1;
                if (cnt == '0) begin
                    state_n = ST_PAYLOAD;
                    cnt_n   = CNT_W'(DATA_W - 1);
                end else begin
                    cnt_n   = cnt - 1'b1;
                end
            end

            ST_PAYLOAD: begin
                ser_n   = shreg[DATA_W-1];
                shreg_n = shreg << 1;
                if (cnt == '0) begin
                    // Last payload bit: open the handshake for the cycle it is
                    // on the line so the next word can follow immediately.
                    done_n  = 1'b1;
                    ready_n = 1'b1;
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n   = cnt - 1'b1;
                end
            end

            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            // NOTE: the payload register is cleared too, so no stale word from an
            // aborted frame can ever reach the line after reset.
            shreg       <= '0;
            ser_data    <= IDLE_BIT;
            sync_active <= 1'b0;
            frame_done  <= 1'b0;
            data_ready  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            shreg       <= shreg_n;
            ser_data    <= ser_n;
            sync_active <= sync_n;
            frame_done  <= done_n;
            data_ready  <= ready_n;
        end
    end

endmodule

// File: tb/tb_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_seq_gen -- self-checking bench for seq_gen.
//
// Main instance (defaults) is checked every cycle against a queue model: each
// accepted word appends the bits of its frame to a queue of future line values,
// and every clock edge pops one value (or idles when the queue is empty).
// Hand tables cover the single-frame, back-to-back, reset and parameter cases.
// -----------------------------------------------------------------------------
module tb_seq_gen;

    localparam logic [7:0] SYNC_W = 8'b10011001;

    logic       clk;
    logic       rst_n;

    // default instance
    logic [7:0] data_in;
    logic       data_valid, data_ready, ser_data, sync_active, frame_done;

    // DATA_W=4, IDLE_BIT=1 instance
    logic [3:0] b_data;
    logic       b_valid, b_ready, b_ser, b_sync, b_done;

    // DATA_W=1 instance
    logic [0:0] c_data;
    logic       c_valid, c_ready, c_ser, c_sync, c_done;

    seq_gen dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .ser_data(ser_data), .sync_active(sync_active),
        .frame_done(frame_done)
    );

    seq_gen #(.DATA_W(4), .IDLE_BIT(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .data_in(b_data), .data_valid(b_valid),
        .data_ready(b_ready), .ser_data(b_ser), .sync_active(b_sync),
        .frame_done(b_done)
    );

    seq_gen #(.DATA_W(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .data_in(c_data), .data_valid(c_valid),
        .data_ready(c_ready), .ser_data(c_ser), .sync_active(c_sync),
        .frame_done(c_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic ser;
        logic sa;
        logic fd;
    } rec_t;

    rec_t q[$];
    rec_t m_out;
    logic m_ready;
    logic m_prev_done;

    function automatic void model_reset();
        q.delete();
        m_out       = '{1'b0, 1'b0, 1'b0};
        m_ready     = 1'b0;
        m_prev_done = 1'b0;
    endfunction

    function automatic void push_frame(input logic [7:0] d);
        logic [7:0] s;
        s = SYNC_W;
        for (int i = 7; i >= 0; i--) q.push_back('{s[i], 1'b1, 1'b0});
        for (int i = 7; i >= 0; i--) q.push_back('{d[i], 1'b0, (i == 0)});
    endfunction

    // One clock edge: a word accepted from an idle line waits one idle cycle;
    // a word accepted while the last bit was on the line starts immediately.
    function automatic void model_edge(input logic v, input logic [7:0] d);
        if (v && m_ready) begin
            if (!m_prev_done) q.push_back('{1'b0, 1'b0, 1'b0});
            push_frame(d);
        end
        if (q.size() > 0) m_out = q.pop_front();
        else              m_out = '{1'b0, 1'b0, 1'b0};
        m_prev_done = m_out.fd;
        m_ready     = (q.size() == 0);
    endfunction

    task automatic tick(input logic v, input logic [7:0] d);
        data_valid = v;
        data_in    = d;
        @(posedge clk);
        model_edge(v, d);
        @(negedge clk);
        check("ser_data",    ser_data,    m_out.ser);
        check("sync_active", sync_active, m_out.sa);
        check("frame_done",  frame_done,  m_out.fd);
        check("data_ready",  data_ready,  m_ready);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       ser;
        logic       sa;
        logic       fd;
        logic       rdy;
    } vec_t;

    vec_t tbl [18];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp32;
        logic [11:0] exp_b;
        logic [8:0]  exp_c;

        // single frame of 8'hA5 from idle: accept, 8 sync bits, 8 payload bits
        tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_n      = 1'b1;
        data_valid = 1'b0;
        data_in    = '0;
        b_valid    = 1'b0;
        b_data     = '0;
        c_valid    = 1'b0;
        c_data     = '0;

        // reset state, checked while rst_n is still low
        #2 rst_n = 1'b0;
        #1;
        check("rst ser_data",    ser_data,    1'b0);
        check("rst sync_active", sync_active, 1'b0);
        check("rst frame_done",  frame_done,  1'b0);
        check("rst data_ready",  data_ready,  1'b0);
        check("rst b ser_data",  b_ser,       1'b1);
        check("rst b data_ready", b_ready,    1'b0);

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        // valid already high on the release edge: ready only rises there
        tick(1'b1, 8'h11);
        check("release ready", data_ready, 1'b1);

        // table-driven single frame
        for (int i = 0; i < 18; i++) begin
            tick(tbl[i].v, tbl[i].d);
            check($sformatf("tbl%0d ser", i), ser_data,    tbl[i].ser);
            check($sformatf("tbl%0d sa", i),  sync_active, tbl[i].sa);
            check($sformatf("tbl%0d fd", i),  frame_done,  tbl[i].fd);
            check($sformatf("tbl%0d rdy", i), data_ready,  tbl[i].rdy);
        end

        // back-to-back: 3C then FF with valid held high
        exp32 = {SYNC_W, 8'h3C, SYNC_W, 8'hFF};
        tick(1'b1, 8'h3C);
        check("b2b lead idle", ser_data, 1'b0);
        for (int i = 1; i <= 33; i++) begin
            tick((i <= 17), 8'hFF);
            if (i <= 32) begin
                check($sformatf("b2b bit%0d", i), ser_data, exp32[32-i]);
                check($sformatf("b2b rdy%0d", i), data_ready, (i == 16 || i == 32));
                check($sformatf("b2b sa%0d", i),  sync_active,
                      (i <= 8) || (i >= 17 && i <= 24));
            end else begin
                check("b2b trailing idle", ser_data, 1'b0);
            end
        end

        // randomized traffic, including valid/data churn mid-frame
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 3) != 0), 8'($urandom));
        end
        // drain to idle
        for (int i = 0; i < 20; i++) tick(1'b0, 8'h00);

        // reset mid-frame while the line is high in the payload
        tick(1'b1, 8'hFF);
        for (int i = 0; i < 12; i++) tick(1'b0, 8'h00);
        check("pre-reset line high", ser_data, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst ser_data",    ser_data,    1'b0);
        check("midrst data_ready",  data_ready,  1'b0);
        check("midrst sync_active", sync_active, 1'b0);
        check("midrst frame_done",  frame_done,  1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick(1'b0, 8'h00);
        check("post-reset ready", data_ready, 1'b1);
        tick(1'b1, 8'h5A);
        for (int i = 0; i < 18; i++) tick(1'b0, 8'h00);

        // DATA_W=4, IDLE_BIT=1: 12-cycle frame of 4'b1010, idles high
        exp_b   = {SYNC_W, 4'b1010};
        check("b idle high", b_ser, 1'b1);
        b_valid = 1'b1;
        b_data  = 4'b1010;
        tick(1'b0, 8'h00);
        b_valid = 1'b0;
        b_data  = 4'b0101;
        check("b lead idle", b_ser, 1'b1);
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 8'h00);
            check($sformatf("b bit%0d", i), b_ser, exp_b[11-i]);
            check($sformatf("b fd%0d", i),  b_done, (i == 11));
            check($sformatf("b sa%0d", i),  b_sync, (i < 8));
        end
        tick(1'b0, 8'h00);
        check("b trailing idle", b_ser, 1'b1);
        check("b ready after", b_ready, 1'b1);

        // DATA_W=1: 9-cycle frame
        exp_c   = {SYNC_W, 1'b1};
        c_valid = 1'b1;
        c_data  = 1'b1;
        tick(1'b0, 8'h00);
        c_valid = 1'b0;
        c_data  = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick(1'b0, 8'h00);
            check($sformatf("c bit%0d", i), c_ser, exp_c[8-i]);
            check($sformatf("c fd%0d", i),  c_done, (i == 8));
        end
        tick(1'b0, 8'h00);
        check("c trailing idle", c_ser, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
